// File: rtl/mul_seq_param.sv
// Sequential shift-add multiplier: M then Q over data_in, one product bit per clock.
// Define MUL_SEQ_SIGNED_EN for two's-complement operands (adds a one-cycle FIX state).
module mul_seq_param #(
   parameter int WIDTH = 32
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic [WIDTH-1:0]   data_in,
   output logic               busy,
   output logic               done,
   output logic [2*WIDTH-1:0] product
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

`ifdef MUL_SEQ_SIGNED_EN
   typedef enum logic [2:0] {IDLE, LOAD_Q, CALC, FIX, DONE} state_t;
`else
   typedef enum logic [2:0] {IDLE, LOAD_Q, CALC, DONE} state_t;
`endif

   state_t             state_reg;
   state_t             state_next;
   logic [WIDTH-1:0]   m_reg;
   logic [WIDTH-1:0]   q_reg;
   logic [WIDTH:0]     a_reg;
   logic [CW-1:0]      cnt_reg;
   logic [2*WIDTH-1:0] product_reg;
   logic [WIDTH-1:0]   in_mag;
   logic [WIDTH:0]     sum;
   logic [WIDTH:0]     a_shift;
   logic [WIDTH-1:0]   q_shift;

`ifdef MUL_SEQ_SIGNED_EN
   logic               in_neg;
   logic               m_neg_reg;
   logic               q_neg_reg;
   logic [2*WIDTH-1:0] mag_prod;

   // The most negative value maps onto 2^(WIDTH-1), which still fits unsigned.
   assign in_neg   = data_in[WIDTH-1];
   assign in_mag   = in_neg ? -data_in : data_in;
   assign mag_prod = {a_reg[WIDTH-1:0], q_reg};
`else
   assign in_mag = data_in;
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) state_reg <= IDLE;
      else        state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      busy       = 1'b0;
      done       = 1'b0;
      case (state_reg)
         IDLE: if (start) state_next = LOAD_Q;
         LOAD_Q: begin
            busy       = 1'b1;
            state_next = CALC;
         end
         CALC: begin
            busy = 1'b1;
            if (cnt_reg == LAST) begin
`ifdef MUL_SEQ_SIGNED_EN
               state_next = FIX;
`else
               state_next = DONE;
`endif
            end
         end
`ifdef MUL_SEQ_SIGNED_EN
         FIX: begin
            busy       = 1'b1;
            state_next = DONE;
         end
`endif
         DONE: begin
            done = 1'b1;
            if (start) state_next = LOAD_Q;
         end
         default: state_next = IDLE;
      endcase
   end

   // One shift-add step; the carry lands in a_reg[WIDTH] before the shift.
   always_comb begin
      sum     = q_reg[0] ? (a_reg + {1'b0, m_reg}) : a_reg;
      a_shift = {1'b0, sum[WIDTH:1]};
      q_shift = {sum[0], q_reg[WIDTH-1:1]};
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         m_reg       <= '0;
         q_reg       <= '0;
         a_reg       <= '0;
         cnt_reg     <= '0;
         product_reg <= '0;
`ifdef MUL_SEQ_SIGNED_EN
         m_neg_reg   <= 1'b0;
         q_neg_reg   <= 1'b0;
`endif
      end else begin
         case (state_reg)
            IDLE, DONE: begin
               if (start) begin
                  m_reg <= in_mag;
`ifdef MUL_SEQ_SIGNED_EN
                  m_neg_reg <= in_neg;
`endif
               end
            end
            LOAD_Q: begin
               q_reg   <= in_mag;
               a_reg   <= '0;
               cnt_reg <= '0;
`ifdef MUL_SEQ_SIGNED_EN
               q_neg_reg <= in_neg;
`endif
            end
            CALC: begin
               a_reg   <= a_shift;
               q_reg   <= q_shift;
               cnt_reg <= cnt_reg + CW'(1);
`ifndef MUL_SEQ_SIGNED_EN
               if (cnt_reg == LAST) product_reg <= {a_shift[WIDTH-1:0], q_shift};
`endif
            end
`ifdef MUL_SEQ_SIGNED_EN
            FIX: product_reg <= (m_neg_reg ^ q_neg_reg) ? -mag_prod : mag_prod;
`endif
            default: ;
         endcase
      end
   end

   assign product = product_reg;

endmodule

// File: doc/mul_seq_param.md
# mul_seq_param

Parametrised sequential shift-add multiplier with an integrated controller. Operands arrive one after another over a shared `data_in` bus: multiplicand M first, then multiplier Q. The product is then computed one bit per clock. The block is the next-generation multiply engine of the datapath/controller family. It generalises the fixed 32-bit unit to any width, adds a busy/done handshake and a held product register, and optionally supports signed operands.

## Interface
- `WIDTH`, default 32: operand width in bits, ≥2; product is `2*WIDTH` bits.
- `clk` input 1: single clock; all state changes on rising edge.
- `rst_n` input 1: synchronous, active-low reset, sampled on rising `clk`.
- `start` input 1: request. Sampled only in IDLE or DONE; ignored otherwise.
- `data_in` input WIDTH: operand bus. Carries M on the start edge and Q on the following edge.
- `busy` output 1: high from the start edge until the product is registered.
- `done` output 1: level, high while in DONE. Product valid while high.
- `product` output 2*WIDTH: result register. Updated only on entry to DONE and held afterwards.

## Operation
- States: IDLE, LOAD_Q, CALC, [FIX], DONE.
- **IDLE:** `start=1` → capture `data_in` as M, go to LOAD_Q. Otherwise stay in IDLE.
- **LOAD_Q:**
  - Capture `data_in` as Q unconditionally.
  - Clear accumulator A (WIDTH+1 bits, includes carry) and iteration counter; go to CALC.
  - `start` is don't-care.
- **CALC:** each cycle:
  - If Q[0]=1, set A = A + {0,M}.
  - Shift {A,Q} right by 1 (logical).
  - Increment counter.
  - After the WIDTH-th iteration, go to FIX if the macro is compiled in, else go to DONE and write {A[WIDTH-1:0],Q} into `product`.
- **DONE:**
  - `done=1`; `product` stable.
  - `start=1` behaves exactly as in IDLE (captures M and clears `done` on the same edge).
  - `start=0` → stay in DONE.
- **Arithmetic:** unsigned by default; exact with no truncation. The carry bit of A covers the WIDTH+1-bit intermediate sum.
- **Boundaries:**
  - `start` during LOAD_Q/CALC/FIX is ignored, and the operation completes unchanged.
  - M=0 or Q=0 → product 0 with the same latency; there is no early exit.
- **Reset:** `rst_n=0` at any edge, including mid-CALC, gives:
  - state = IDLE; `busy` = 0; `done` = 0; `product` = 0.
  - M, Q, A and counter cleared.
  - The operation in flight is discarded.

## Timing
- Edge E0: `start` sampled high, M loaded, `busy`=1.
- Edge E1: Q loaded.
- Edges E2..E(WIDTH+1): WIDTH iterations.
- Unsigned build: `done`=1 and `product` valid after E(WIDTH+1), i.e. WIDTH+1 cycles after the start edge. `busy` drops on the same edge.
- Signed build: one extra cycle; `done` after E(WIDTH+2).
- Back-to-back throughput: a new `start` is accepted on the first edge in DONE. Each operation therefore costs WIDTH+2 cycles (WIDTH+3 signed), start edge included.
- Reset values: `busy`=0, `done`=0, `product`=0.

## Configuration
- `MUL_SEQ_SIGNED_EN` defined:
  - Operands are two's complement.
  - At load time, sign bits are recorded and magnitudes are stored. |−2^(WIDTH−1)| = 2^(WIDTH−1) fits in WIDTH unsigned bits.
  - CALC multiplies the magnitudes.
  - The FIX state (1 cycle) negates the 2*WIDTH result when the signs differ, then writes `product` and enters DONE.
- Not defined: unsigned only; no FIX state and no sign logic.

## Test plan
- **Basic unsigned** (WIDTH=32): `start` with `data_in`=2, next cycle `data_in`=3 → `done` after 33 cycles, `product`=6, `busy` low on the same edge.
- **Max operands:** M=Q=0xFFFFFFFF → `product`=0xFFFFFFFE00000001; the carry path is exercised.
- **Signed** (macro on): M=−2 (0xFFFFFFFE), Q=3 → `product`=0xFFFFFFFFFFFFFFFA after 34 cycles. M=Q=0x80000000 → 0x4000000000000000.
- **Protocol:** pulse `start` repeatedly during CALC → result and latency unchanged. `start` in DONE with M=5, then Q=7 → `done` drops next edge, then `product`=35.
- **Reset mid-CALC:** assert `rst_n`=0 at iteration 10 → next edge shows `busy`=0, `done`=0, `product`=0. A fresh 4×4 then yields 16.
- **Exhaustive small width:** WIDTH=4, all 256 operand pairs, both macro settings → `product` matches the reference model every time, with fixed latency.
